// File: rtl/phase_diff.sv
// phase_diff: wrapped phase difference between consecutive angle samples
// (instantaneous frequency) plus a sliding-window average of that difference.
module phase_diff #(
  parameter int unsigned ANGLEBITSIZE = 19,
  parameter int unsigned FRACBITS     = 10,
  parameter int unsigned PI_Q         = 3217,
  parameter int unsigned AVGLOG2      = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    angle_valid,
  input  logic [ANGLEBITSIZE-1:0] angle,
  output logic                    freq_valid,
  output logic [ANGLEBITSIZE-1:0] freq,
  output logic                    avg_valid,
  output logic [ANGLEBITSIZE-1:0] avg_freq
);

  localparam int unsigned W  = ANGLEBITSIZE;
  localparam int unsigned DW = ANGLEBITSIZE + 1;
  localparam int unsigned SW = ANGLEBITSIZE + AVGLOG2;
  localparam int unsigned N  = 1 << AVGLOG2;
  localparam int unsigned CW = AVGLOG2 + 1;

  localparam logic signed [DW-1:0] PI_D     = DW'(PI_Q);
  localparam logic signed [DW-1:0] NEG_PI_D = -PI_D;
  localparam logic signed [DW-1:0] TWO_PI_D = DW'(2 * PI_Q);

  // pi needs a sign bit and two integer bits on top of the fraction
  if (FRACBITS + 3 > ANGLEBITSIZE) begin : g_fmt_check
    $error("phase_diff: FRACBITS too large for ANGLEBITSIZE");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   take_prev;
  logic   emit_freq;

  logic signed [W-1:0]  angle_s;
  logic signed [W-1:0]  prev_q;
  logic signed [DW-1:0] diff_raw;
  logic [W-1:0]         freq_d;

  logic signed [W-1:0]  freq_s;
  logic signed [W-1:0]  hist_q [N];
  logic [AVGLOG2-1:0]   ptr_q;
  logic [CW-1:0]        fill_q;
  logic [CW-1:0]        fill_nx;
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] sum_d;

  assign angle_s = angle;
  assign freq_s  = freq;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next state: first sample only primes prev, later samples emit a delta; clear wins
  always_comb begin
    state_d   = state_q;
    take_prev = 1'b0;
    emit_freq = 1'b0;
    if (clear) begin
      state_d = EMPTY;
    end else if (angle_valid) begin
      take_prev = 1'b1;
      emit_freq = (state_q == RUN);
      state_d   = RUN;
    end
  end

  // Raw difference one bit wider, folded back into [-pi, pi]
  always_comb begin
    diff_raw = DW'(angle_s) - DW'(prev_q);
    if (diff_raw > PI_D)          freq_d = W'(diff_raw - TWO_PI_D);
    else if (diff_raw < NEG_PI_D) freq_d = W'(diff_raw + TWO_PI_D);
    else                          freq_d = W'(diff_raw);
  end

  // Frequency stage: previous angle and registered delta
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      freq       <= '0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= emit_freq;
      if (take_prev) prev_q <= angle_s;
      if (emit_freq) freq   <= freq_d;
    end
  end

  // Running sum replaces the oldest window entry with the newest delta
  always_comb begin
    sum_d   = sum_q + SW'(freq_s) - SW'(hist_q[ptr_q]);
    fill_nx = (fill_q == CW'(N)) ? fill_q : fill_q + CW'(1);
  end

  // Averaging stage: consumes each freq strobe one cycle later
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) hist_q[i] <= '0;
      ptr_q     <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      avg_valid <= 1'b0;
      avg_freq  <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < N; i++) hist_q[i] <= '0;
      ptr_q     <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (freq_valid) begin
        hist_q[ptr_q] <= freq_s;
        ptr_q         <= ptr_q + AVGLOG2'(1);
        fill_q        <= fill_nx;
        sum_q         <= sum_d;
        if (fill_nx == CW'(N)) begin
          avg_valid <= 1'b1;
          avg_freq  <= W'(sum_d >>> AVGLOG2);
        end
      end
    end
  end

endmodule

// File: doc/phase_diff.md
# phase_diff

Downstream stage of `phasecalc` in the HilbertFilter receive chain. Takes the stream of phase angles produced per complex sample, forms the wrapped phase difference between consecutive samples (instantaneous frequency, radians/sample), and also outputs a sliding-window average of that difference for the demodulator/decision logic. Registered every output; accepts one angle per clock.

## Interface
- `ANGLEBITSIZE`, 19, width of input angle and `freq`; signed, `FRACBITS` fractional bits
- `FRACBITS`, 10, fractional bits of angle/frequency format
- `PI_Q`, 3217, pi in the fixed-point format (round(pi·2^10))
- `AVGLOG2`, 3, log2 of averaging window length N (N = 8)

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous restart of history (active-high)
- `angle_valid`  in  1  one-cycle strobe: `angle` holds a new sample (driven from phasecalc completion)
- `angle`  in  ANGLEBITSIZE  signed angle in [-PI_Q, PI_Q]
- `freq_valid`  out  1  one-cycle strobe: `freq` updated
- `freq`  out  ANGLEBITSIZE  signed wrapped phase difference
- `avg_valid`  out  1  one-cycle strobe: `avg_freq` updated
- `avg_freq`  out  ANGLEBITSIZE  signed window average of `freq`

## Operation
- States: EMPTY (no previous angle) and RUN.
- EMPTY: on `angle_valid`, store `angle` in `prev`, go to RUN; no `freq_valid`.
- RUN: on `angle_valid`, d = angle − prev computed at ANGLEBITSIZE+1 bits; if d > PI_Q then d −= 2·PI_Q; else if d < −PI_Q then d += 2·PI_Q; d = ±PI_Q left unchanged. Result fits ANGLEBITSIZE. `freq` <= d, `prev` <= angle.
- Averaging: circular buffer of N deltas, write pointer wraps N−1 → 0; running sum (ANGLEBITSIZE+AVGLOG2 bits) updated as sum + d_new − d_oldest. Fill counter saturates at N.
- `avg_freq` = sum >>> AVGLOG2 (arithmetic shift, floor toward −inf). `avg_valid` only fires once N deltas have entered since last reset/clear; every delta after that produces one.
- `clear`: return to EMPTY, zero buffer, sum, fill counter, pointer; outputs `freq`/`avg_freq` hold last value, strobes low. If `clear` and `angle_valid` coincide, clear wins and the sample is dropped.
- `reset` (low): same as clear plus `freq`, `avg_freq` = 0, `freq_valid` = `avg_valid` = 0, state EMPTY. Applies immediately, mid-stream included.

## Timing
- `freq_valid`/`freq`: 1 cycle after the `angle_valid` edge that produced them.
- `avg_valid`/`avg_freq`: 2 cycles after that `angle_valid` (1 cycle after the matching `freq_valid`).
- `angle_valid` may be asserted every cycle; no back-pressure, no stalls, no dropped samples except under `clear`/reset.
- Strobes are single-cycle per input sample; `freq` and `avg_freq` hold between strobes.
- Reset values: `freq_valid`=0, `avg_valid`=0, `freq`=0, `avg_freq`=0.

## Test plan
- Reset then angle 1000: no `freq_valid`, no `avg_valid`, all outputs 0; during reset, strobes stay 0 despite `angle_valid`.
- Angles 1000, 1500 on consecutive cycles: `freq`=500 with `freq_valid` one cycle after the second strobe.
- Wrap: 3000 → −3000 gives `freq`=434; −3000 → 3000 gives `freq`=−434; boundary 0 → 3217 gives 3217, 0 → 3218 gives −3216.
- Average: angles 0,100,…,800 (9 samples, back-to-back): `avg_valid` first after the 8th delta, `avg_freq`=100; then nine angles of step −1: `avg_freq` steps down to −1 (floor), never 0 once all 8 deltas are −1.
- Average window sliding: deltas 8×(+16) then one −112 → sum 0, `avg_freq`=0 on that strobe (checks oldest-entry subtraction and pointer wrap).
- `clear` coincident with `angle_valid` mid-stream: sample dropped, next angle treats as first (no `freq_valid`), `avg_valid` absent until 8 new deltas; repeat with `reset` pulsed low mid-stream: outputs go 0 asynchronously.
